// File: rtl/cp0_regfile_if.sv
// cp0_regfile_if: MTC0/MFC0 ports, committed exception fields and redirect outputs
// exchanged between the execute/commit stages and the CP0 register file.
interface cp0_regfile_if #(
    parameter int unsigned EXC_CODE_WIDTH = 5
) ();
    logic                      we_i;
    logic [4:0]                waddr_i;
    logic [31:0]               wdata_i;
    logic [4:0]                raddr_i;
    logic [31:0]               rdata_o;
    logic [EXC_CODE_WIDTH-1:0] exc_code_i;
    logic [31:0]               exc_epc_i;
    logic [31:0]               exc_badvaddr_i;
    logic                      exc_in_delay_i;
    logic                      flush_o;
    logic [31:0]               new_pc_o;

    modport master (
        output we_i, waddr_i, wdata_i, raddr_i,
        output exc_code_i, exc_epc_i, exc_badvaddr_i, exc_in_delay_i,
        input  rdata_o, flush_o, new_pc_o
    );

    modport slave (
        input  we_i, waddr_i, wdata_i, raddr_i,
        input  exc_code_i, exc_epc_i, exc_badvaddr_i, exc_in_delay_i,
        output rdata_o, flush_o, new_pc_o
    );
endinterface

// File: rtl/cp0_regfile.sv
// cp0_regfile: CP0 BadVAddr/Count/Compare/Status/Cause/EPC with exception and ERET redirect.
// Optional macro CP0_TIMER_EN builds Count, Compare and the timer interrupt.
module cp0_regfile #(
    parameter int unsigned                EXC_CODE_WIDTH = 5,
    parameter logic [EXC_CODE_WIDTH-1:0] EC_NONE        = EXC_CODE_WIDTH'(5'h10),
    parameter logic [EXC_CODE_WIDTH-1:0] EC_ERET        = EXC_CODE_WIDTH'(5'h11),
    parameter logic [31:0]               EXC_VECTOR     = 32'hBFC0_0380
) (
    input  logic                clk,
    input  logic                rst,
    cp0_regfile_if.slave        bus,
    input  logic [5:0]          int_i,
    output logic [31:0]         status_o,
    output logic [31:0]         cause_o,
    output logic [31:0]         epc_o,
    output logic                int_pending_o
);
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] epc_q, epc_d;
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exccode_q, exccode_d;

    logic        timer_int;
    logic        exc, eret;
    logic        wr_status, wr_cause, wr_epc;
    logic [31:0] status_rd, cause_rd, count_rd, compare_rd, rdata;

    assign exc  = (bus.exc_code_i != EC_NONE) && (bus.exc_code_i != EC_ERET);
    assign eret = (bus.exc_code_i == EC_ERET);

    assign status_rd = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_rd  = {bd_q, 15'b0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b0};

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        toggle_q, toggle_d;
    logic        timer_q, timer_d;
    logic        wr_count, wr_compare;

    // Count advances every other cycle; a Compare write always wins over a match.
    always_comb begin
        wr_count   = bus.we_i && (bus.waddr_i == REG_COUNT);
        wr_compare = bus.we_i && (bus.waddr_i == REG_COMPARE);
        toggle_d   = ~toggle_q;
        count_d    = toggle_q ? count_q + 32'd1 : count_q;
        compare_d  = compare_q;
        timer_d    = timer_q;
        if (wr_count) begin
            count_d  = bus.wdata_i;
            toggle_d = 1'b0;
        end
        if (wr_compare) begin
            compare_d = bus.wdata_i;
            timer_d   = 1'b0;
        end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
            timer_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            toggle_q  <= 1'b0;
            timer_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            toggle_q  <= toggle_d;
            timer_q   <= timer_d;
        end
    end

    assign timer_int  = timer_q;
    assign count_rd   = count_q;
    assign compare_rd = compare_q;
`else
    assign timer_int  = 1'b0;
    assign count_rd   = 32'd0;
    assign compare_rd = 32'd0;
`endif

    // MFC0 read mux with same-cycle MTC0 bypass of the value being written.
    always_comb begin
        rdata = 32'd0;
        case (bus.raddr_i)
            REG_BADVADDR: rdata = badvaddr_q;
            REG_COUNT:    rdata = count_rd;
            REG_COMPARE:  rdata = compare_rd;
            REG_STATUS:   rdata = status_rd;
            REG_CAUSE:    rdata = cause_rd;
            REG_EPC:      rdata = epc_q;
            default:      rdata = 32'd0;
        endcase
        if (bus.we_i && (bus.waddr_i == bus.raddr_i)) begin
            case (bus.raddr_i)
`ifdef CP0_TIMER_EN
                REG_COUNT, REG_COMPARE: rdata = bus.wdata_i;
`endif
                REG_STATUS: rdata = (bus.wdata_i & 32'h0000_FF03) | 32'h0040_0000;
                REG_CAUSE:  rdata = {cause_rd[31:10], bus.wdata_i[9:8], cause_rd[7:0]};
                REG_EPC:    rdata = bus.wdata_i;
                default:    ;
            endcase
        end
    end

    // Exception/ERET commit; they pre-empt same-cycle MTC0 to Status/Cause/EPC.
    always_comb begin
        wr_status = bus.we_i && (bus.waddr_i == REG_STATUS) && !exc && !eret;
        wr_cause  = bus.we_i && (bus.waddr_i == REG_CAUSE)  && !exc && !eret;
        wr_epc    = bus.we_i && (bus.waddr_i == REG_EPC)    && !exc && !eret;
        badvaddr_d = badvaddr_q;
        epc_d      = epc_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_sw_d    = ip_sw_q;
        exccode_d  = exccode_q;
        ip_hw_d    = {int_i[5] | timer_int, int_i[4:0]};
        if (wr_status) begin
            im_d  = bus.wdata_i[15:8];
            exl_d = bus.wdata_i[1];
            ie_d  = bus.wdata_i[0];
        end
        if (wr_cause) ip_sw_d = bus.wdata_i[9:8];
        if (wr_epc)   epc_d   = bus.wdata_i;
        if (exc) begin
            if (!exl_q) begin
                epc_d = bus.exc_in_delay_i ? bus.exc_epc_i - 32'd4 : bus.exc_epc_i;
                bd_d  = bus.exc_in_delay_i;
            end
            exl_d     = 1'b1;
            exccode_d = bus.exc_code_i[4:0];
            if ((bus.exc_code_i == EXC_CODE_WIDTH'(4)) || (bus.exc_code_i == EXC_CODE_WIDTH'(5)))
                badvaddr_d = bus.exc_badvaddr_i;
        end else if (eret) begin
            exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            badvaddr_q <= 32'd0;
            epc_q      <= 32'd0;
            im_q       <= 8'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_hw_q    <= 6'd0;
            ip_sw_q    <= 2'd0;
            exccode_q  <= 5'd0;
        end else begin
            badvaddr_q <= badvaddr_d;
            epc_q      <= epc_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            exccode_q  <= exccode_d;
        end
    end

    assign bus.rdata_o  = rdata;
    assign bus.flush_o  = exc | eret;
    assign bus.new_pc_o = exc  ? EXC_VECTOR :
                          eret ? ((bus.we_i && (bus.waddr_i == REG_EPC)) ? bus.wdata_i : epc_q) :
                                 32'd0;

    assign status_o      = status_rd;
    assign cause_o       = cause_rd;
    assign epc_o         = epc_q;
    assign int_pending_o = ie_q & ~exl_q & (|({ip_hw_q, ip_sw_q} & im_q));
endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: directed plus random stimulus for cp0_regfile, scored against a
// word-level reference model through an expectation queue popped by a monitor.
module tb_cp0_regfile;
    localparam logic [4:0]  EC_NONE    = 5'h10;
    localparam logic [4:0]  EC_ERET    = 5'h11;
    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;
    localparam logic [31:0] BEV        = 32'h0040_0000;

    logic        clk;
    logic        rst;
    logic [5:0]  int_i;
    logic [31:0] status_o, cause_o, epc_o;
    logic        int_pending_o;

    cp0_regfile_if #(.EXC_CODE_WIDTH(5)) bus ();

    cp0_regfile #(
        .EXC_CODE_WIDTH(5),
        .EC_NONE       (EC_NONE),
        .EC_ERET       (EC_ERET),
        .EXC_VECTOR    (EXC_VECTOR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .int_i        (int_i),
        .status_o     (status_o),
        .cause_o      (cause_o),
        .epc_o        (epc_o),
        .int_pending_o(int_pending_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          id;
        logic        chk_rd;
        logic [31:0] rd;
        logic        flush;
        logic [31:0] npc;
        logic [31:0] st;
        logic [31:0] ca;
        logic [31:0] ep;
        logic        ip;
    } exp_t;

    exp_t sb[$];
    int   total   = 0;
    int   bad     = 0;
    int   step_id = 0;
    logic [5:0] irq_hold = 6'd0;

    // Reference model: architectural registers as whole words.
    logic [31:0] m_badv, m_status, m_cause, m_epc;
    logic        m_timer;
    logic [31:0] m_cnt_base, m_compare;
    int unsigned m_cnt_cyc;

    function automatic logic [31:0] m_count();
        return m_cnt_base + 32'(m_cnt_cyc / 2);
    endfunction

    task automatic m_reset();
        m_badv     = 32'd0;
        m_status   = BEV;
        m_cause    = 32'd0;
        m_epc      = 32'd0;
        m_timer    = 1'b0;
        m_cnt_base = 32'd0;
        m_cnt_cyc  = 0;
        m_compare  = 32'd0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:  return m_badv;
`ifdef CP0_TIMER_EN
            5'd9:  return m_count();
            5'd11: return m_compare;
`endif
            5'd12: return m_status;
            5'd13: return m_cause;
            5'd14: return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_update(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                            input logic [4:0] ec, input logic [31:0] pc,
                            input logic [31:0] bva, input logic dly, input logic [5:0] irq);
        logic exc, eret, old_timer;
        exc       = (ec != EC_NONE) && (ec != EC_ERET);
        eret      = (ec == EC_ERET);
        old_timer = m_timer;
`ifdef CP0_TIMER_EN
        if (we && wa == 5'd11) m_timer = 1'b0;
        else if (m_count() == m_compare && m_compare != 32'd0) m_timer = 1'b1;
        if (we && wa == 5'd11) m_compare = wd;
        if (we && wa == 5'd9) begin
            m_cnt_base = wd;
            m_cnt_cyc  = 0;
        end else begin
            m_cnt_cyc = m_cnt_cyc + 1;
        end
`endif
        m_cause = (m_cause & ~32'h0000_FC00) | (32'({irq[5] | old_timer, irq[4:0]}) << 10);
        if (we && !exc && !eret) begin
            if (wa == 5'd12) m_status = (wd & 32'h0000_FF03) | BEV;
            if (wa == 5'd13) m_cause  = (m_cause & ~32'h0000_0300) | (wd & 32'h0000_0300);
            if (wa == 5'd14) m_epc    = wd;
        end
        if (exc) begin
            if (!m_status[1]) begin
                m_epc      = dly ? pc - 32'd4 : pc;
                m_cause[31] = dly;
            end
            m_status[1]   = 1'b1;
            m_cause[6:2]  = ec;
            if (ec == 5'd4 || ec == 5'd5) m_badv = bva;
        end else if (eret) begin
            m_status[1] = 1'b0;
        end
    endtask

    // One clock of stimulus: drive, queue the expected outputs, advance the model.
    task automatic step(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra, input logic [4:0] ec, input logic [31:0] pc,
                        input logic [31:0] bva, input logic dly, input logic [5:0] irq);
        exp_t e;
        logic exc, eret;
        rst                = r;
        bus.we_i           = we;
        bus.waddr_i        = wa;
        bus.wdata_i        = wd;
        bus.raddr_i        = ra;
        bus.exc_code_i     = ec;
        bus.exc_epc_i      = pc;
        bus.exc_badvaddr_i = bva;
        bus.exc_in_delay_i = dly;
        int_i              = irq;
        if (!r) m_reset();
        exc      = (ec != EC_NONE) && (ec != EC_ERET);
        eret     = (ec == EC_ERET);
        e.id     = step_id;
        e.chk_rd = 1'b1;
        e.rd     = m_read(ra);
        if (we && wa == ra) begin
            case (ra)
`ifdef CP0_TIMER_EN
                5'd9, 5'd11: e.rd = wd;
`endif
                5'd12:       e.rd = (wd & 32'h0000_FF03) | BEV;
                5'd14:       e.rd = wd;
                5'd8, 5'd13: e.chk_rd = 1'b0;
                default:     ;
            endcase
        end
        e.flush = exc | eret;
        e.npc   = exc ? EXC_VECTOR : eret ? ((we && wa == 5'd14) ? wd : m_epc) : 32'd0;
        e.st    = m_status;
        e.ca    = m_cause;
        e.ep    = m_epc;
        e.ip    = m_status[0] & ~m_status[1] & (|(m_cause[15:8] & m_status[15:8]));
        sb.push_back(e);
        @(posedge clk);
        if (r) m_update(we, wa, wd, ec, pc, bva, dly, irq);
        step_id = step_id + 1;
        #1;
    endtask

    task automatic idle(input logic [4:0] ra);
        step(1'b1, 1'b0, 5'd0, 32'd0, ra, EC_NONE, 32'd0, 32'd0, 1'b0, irq_hold);
    endtask

    task automatic mtc0(input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] ra);
        step(1'b1, 1'b1, wa, wd, ra, EC_NONE, 32'd0, 32'd0, 1'b0, irq_hold);
    endtask

    task automatic raise(input logic [4:0] ec, input logic [31:0] pc, input logic [31:0] bva,
                         input logic dly, input logic [4:0] ra);
        step(1'b1, 1'b0, 5'd0, 32'd0, ra, ec, pc, bva, dly, irq_hold);
    endtask

    function automatic logic [4:0] pick_addr();
        case ($urandom_range(0, 7))
            0: return 5'd8;
            1: return 5'd9;
            2: return 5'd11;
            3: return 5'd12;
            4: return 5'd13;
            5: return 5'd14;
            6: return 5'd0;
            default: return 5'($urandom_range(15, 31));
        endcase
    endfunction

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s step=%0d actual=%h required=%h", name, id, act, req);
        end
    endtask

    // Monitor: combinational outputs are stable mid-cycle, so score on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.chk_rd) chk("rdata", e.id, bus.rdata_o, e.rd);
            chk("flush",       e.id, 32'(bus.flush_o), 32'(e.flush));
            chk("new_pc",      e.id, bus.new_pc_o, e.npc);
            chk("status",      e.id, status_o, e.st);
            chk("cause",       e.id, cause_o, e.ca);
            chk("epc",         e.id, epc_o, e.ep);
            chk("int_pending", e.id, 32'(int_pending_o), 32'(e.ip));
        end
    end

    initial begin
        logic        r, we, dly;
        logic [4:0]  wa, ra, ec;
        logic [31:0] wd, pc, bva;
        int unsigned k;
        m_reset();
        rst = 1'b0;
        bus.we_i = 1'b0; bus.waddr_i = 5'd0; bus.wdata_i = 32'd0; bus.raddr_i = 5'd0;
        bus.exc_code_i = EC_NONE; bus.exc_epc_i = 32'd0; bus.exc_badvaddr_i = 32'd0;
        bus.exc_in_delay_i = 1'b0; int_i = 6'd0;
        @(posedge clk);
        #1;

        // Reset values, then a write lost to a reset asserted in the same cycle.
        step(1'b0, 1'b0, 5'd0, 32'd0, 5'd12, EC_NONE, 32'd0, 32'd0, 1'b0, 6'd0);
        idle(5'd8); idle(5'd9); idle(5'd11); idle(5'd12); idle(5'd13); idle(5'd14);
        step(1'b0, 1'b1, 5'd14, 32'h1234_5678, 5'd12, EC_NONE, 32'd0, 32'd0, 1'b0, 6'd0);
        idle(5'd14);

        // Status write mask and same-cycle bypass.
        mtc0(5'd12, 32'hFFFF_FFFF, 5'd12);
        idle(5'd12);
        mtc0(5'd12, 32'h0000_0000, 5'd12);

        // Delay-slot address-error exception, then a nested one while EXL=1.
        raise(5'd4, 32'h8000_0104, 32'h0000_0003, 1'b1, 5'd14);
        idle(5'd14); idle(5'd13); idle(5'd8); idle(5'd12);
        raise(5'd5, 32'h9000_0000, 32'h0000_0044, 1'b0, 5'd14);
        idle(5'd14); idle(5'd8);

        // ERET returns to EPC and clears EXL; then ERET with a forwarded EPC write.
        raise(EC_ERET, 32'd0, 32'd0, 1'b0, 5'd12);
        idle(5'd12);
        step(1'b1, 1'b1, 5'd14, 32'h8000_2000, 5'd14, EC_ERET, 32'd0, 32'd0, 1'b0, 6'd0);
        idle(5'd14);

`ifdef CP0_TIMER_EN
        // Timer match, interrupt, clear by Compare write, and Count wrap.
        mtc0(5'd12, 32'h0040_8001, 5'd12);
        mtc0(5'd11, 32'd10, 5'd11);
        mtc0(5'd9, 32'd0, 5'd9);
        for (int i = 0; i < 26; i++) idle(5'd9);
        mtc0(5'd11, 32'd10, 5'd13);
        idle(5'd13); idle(5'd13);
        mtc0(5'd9, 32'hFFFF_FFFF, 5'd9);
        idle(5'd9); idle(5'd9); idle(5'd9);
`endif

        // External interrupt line 0 through IM[2], then masked by EXL.
        mtc0(5'd12, 32'h0000_0401, 5'd12);
        irq_hold = 6'b000001;
        idle(5'd13); idle(5'd13); idle(5'd13);
        mtc0(5'd12, 32'h0000_0403, 5'd12);
        idle(5'd12); idle(5'd12);
        irq_hold = 6'd0;
        idle(5'd13);

        // Randomized traffic including simultaneous writes/exceptions and rare resets.
        for (int i = 0; i < 800; i++) begin
            r   = ($urandom_range(0, 99) != 0);
            we  = 1'($urandom_range(0, 1));
            wa  = pick_addr();
            ra  = ($urandom_range(0, 3) == 0) ? wa : pick_addr();
            wd  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            k   = $urandom_range(0, 9);
            ec  = (k < 7) ? EC_NONE : (k == 7) ? EC_ERET : 5'($urandom_range(0, 15));
            pc  = $urandom;
            bva = $urandom;
            dly = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) irq_hold = 6'($urandom);
            step(r, we, wa, wd, ra, ec, pc, bva, dly, irq_hold);
        end
        idle(5'd0);

        repeat (2) @(posedge clk);
        total = total + 1;
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 register file; the responder to the execute stage's MFC0/MTC0 read/write ports and to the exception fields (code, EPC, BadVAddr) it pipelines down.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC.
- Records exceptions and ERET, generates the timer interrupt, and drives redirect (flush_o/new_pc_o) and interrupt-pending signals back to the pipeline.

Parameters:
- EXC_CODE_WIDTH, 5, width of exc_code_i.
- EC_NONE, 5'h10, exc_code_i value meaning no exception.
- EC_ERET, 5'h11, exc_code_i value meaning ERET.
- EXC_VECTOR, 32'hBFC00380, exception redirect target.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- we_i  in  1  MTC0 write enable.
- waddr_i  in  5  MTC0 register number.
- wdata_i  in  32  MTC0 data.
- raddr_i  in  5  MFC0 register number.
- rdata_o  out  32  MFC0 read data (combinational).
- exc_code_i  in  EXC_CODE_WIDTH  committed exception code, EC_NONE or EC_ERET.
- exc_epc_i  in  32  PC of the faulting instruction.
- exc_badvaddr_i  in  32  faulting address.
- exc_in_delay_i  in  1  faulting instruction is in a delay slot.
- int_i  in  6  external hardware interrupt lines.
- status_o  out  32  current Status.
- cause_o  out  32  current Cause.
- epc_o  out  32  current EPC.
- int_pending_o  out  1  unmasked interrupt pending.
- flush_o  out  1  pipeline redirect this cycle.
- new_pc_o  out  32  redirect target.

Behaviour:
- Reset (rst=0, asynchronous):
  - BadVAddr=0, Count=0, Compare=0, EPC=0, Cause=0.
  - Status=32'h0040_0000 (BEV=1).
  - Internal half-rate toggle=0; timer_int=0.
  - All outputs derive from these values, so flush_o=0, new_pc_o=0, int_pending_o=0.
  - Reset mid-operation discards any pending write or exception.
- Register map: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. Any other address reads 0; writes to it are ignored.
- Write masks:
  - Status: only IM[15:8], EXL[1], IE[0] are writable; BEV[22] is hardwired 1; all other bits read 0.
  - Cause: only IP[9:8] (software interrupts) are writable.
  - BadVAddr: read-only; writes are ignored.
  - Count, Compare, EPC: fully writable.
- Read path:
  - rdata_o = register[raddr_i], combinational.
  - Same-cycle bypass: if we_i=1 and waddr_i==raddr_i, rdata_o returns the masked wdata_i.
- Count:
  - The toggle flips every cycle; Count increments when toggle=1, i.e. every 2 cycles. It wraps 32'hFFFF_FFFF -> 0.
  - An MTC0 to Count loads wdata_i and resets the toggle to 0.
- Timer interrupt:
  - timer_int is set the cycle after Count==Compare with Compare!=0.
  - It stays set until an MTC0 to Compare, which clears it.
- Cause.IP update (every cycle):
  - IP[7] = int_i[5] | timer_int.
  - IP[6:2] = int_i[4:0].
- int_pending_o = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]).
- Exception (exc_code_i not EC_NONE/EC_ERET), on the clock edge:
  - If Status.EXL==0:
    - EPC = exc_in_delay_i ? exc_epc_i-4 : exc_epc_i.
    - Cause.BD[31] = exc_in_delay_i.
  - Status.EXL=1.
  - Cause.ExcCode[6:2] = exc_code_i[4:0].
  - If the code is 4 (AdEL) or 5 (AdES): BadVAddr = exc_badvaddr_i.
  - flush_o=1 and new_pc_o=EXC_VECTOR, combinationally in the same cycle as exc_code_i.
- ERET:
  - Status.EXL=0 on the edge.
  - flush_o=1 and new_pc_o=EPC, combinationally in the same cycle; a same-cycle MTC0 to EPC forwards wdata_i.
- Otherwise flush_o=0 and new_pc_o=0.
- Simultaneous events:
  - Exception or ERET beats a same-cycle MTC0 to Status/Cause/EPC/BadVAddr; those writes are dropped.
  - Writes to Count/Compare still take effect.
  - An MTC0 to Count beats the increment.
  - An MTC0 to Compare clears timer_int even if Count==Compare that same cycle.

Optional Feature:
- Macro CP0_TIMER_EN.
- Defined: Count, Compare and timer_int behave as specified above.
- Undefined:
  - Count and Compare are not implemented; reads return 0 and writes are ignored.
  - timer_int is constant 0, so IP[7] = int_i[5] only.
  - The toggle logic is removed.

Test Plan:
- Reset check: release rst, read all six registers -> Status=32'h0040_0000, all others 0, flush_o=0. Then assert rst mid-write -> the write is lost.
- Status mask: MTC0 Status 32'hFFFF_FFFF -> read 32'h0040_FF03. Same-cycle MFC0 Status -> bypass returns 32'h0040_FF03.
- Delay-slot exception: exc_code_i=4, exc_epc_i=32'h8000_0104, exc_badvaddr_i=32'h0000_0003, exc_in_delay_i=1. Expect:
  - flush_o=1, new_pc_o=32'hBFC0_0380 in that cycle.
  - Next cycle EPC=32'h8000_0100, Cause.BD=1, ExcCode=4, BadVAddr=3, EXL=1.
  - A second exception while EXL=1 -> EPC unchanged.
- ERET: with EPC=32'h8000_0100, apply exc_code_i=EC_ERET -> flush_o=1, new_pc_o=32'h8000_0100, EXL=0 next cycle.
- Timer (CP0_TIMER_EN): write Compare=10, Count=0 -> timer_int is set after ~20 cycles. With Status=32'h0040_8001, int_pending_o=1. Writing Compare clears it. Separately, Count=32'hFFFF_FFFF wraps to 0 after 2 cycles.
- External interrupt: int_i=6'b000001 with IM[2]=1, IE=1, EXL=0 -> Cause.IP[2]=1 and int_pending_o=1 next cycle. Set EXL=1 -> int_pending_o=0.
